// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats,
// op_class codes and the decoded-instruction bundle.
package decode_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic [3:0] {
        CLS_INVALID = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OPIMM   = 4'd8,
        CLS_OP      = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11
    } op_class_e;

    typedef struct packed {
        logic rd_we;
        logic rs1_en;
        logic rs2_en;
        logic imm_en;
        logic imm_b_sel;
        logic pc_a_sel;
        logic alu_en;
        logic mem_en;
        logic mem_write;
        logic is_jal;
        logic is_jalr;
        logic is_branch;
        logic is_fence;
        logic is_system;
    } ctl_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       alu_flag;
        op_class_e  op_class;
        ctl_t       ctl;
        logic       invalid;
    } dec_t;

    // 32-bit immediate; the caller sign-extends to XLEN.
    function automatic logic [31:0] imm_gen(
        input logic [31:7] i,
        input imm_fmt_e    f
    );
        logic [31:0] r;
        r = '0;
        case (f)
            IMM_I: r = {{20{i[31]}}, i[31:20]};
            IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B: r = {{19{i[31]}}, i[31], i[7],
                        i[30:25], i[11:8], 1'b0};
            IMM_U: r = {i[31:12], 12'b0};
            IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                        i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of decode_queue.
// slave = queue view, master = fetch/execute view.
interface decode_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            alu_flag;
    logic [XLEN-1:0] imm;
    logic [3:0]      op_class;

    logic rd_we, rs1_en, rs2_en, imm_en, imm_b_sel;
    logic pc_a_sel, alu_en, mem_en, mem_write;
    logic is_jal, is_jalr, is_branch, is_fence;
    logic is_system, is_invalid;

    logic [7:0] inv_cnt;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc,
        output rd, rs1, rs2, funct3, alu_flag, imm, op_class,
        output rd_we, rs1_en, rs2_en, imm_en, imm_b_sel,
        output pc_a_sel, alu_en, mem_en, mem_write,
        output is_jal, is_jalr, is_branch, is_fence,
        output is_system, is_invalid, inv_cnt
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc,
        input  rd, rs1, rs2, funct3, alu_flag, imm, op_class,
        input  rd_we, rs1_en, rs2_en, imm_en, imm_b_sel,
        input  pc_a_sel, alu_en, mem_en, mem_write,
        input  is_jal, is_jalr, is_branch, is_fence,
        input  is_system, is_invalid, inv_cnt
    );

endinterface

// File: rtl/inst_decode_comb.sv
// Purely combinational RV32I/RV32E instruction decoder.
module inst_decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic [31:0]     inst,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    localparam bit RV32E = (NREGS == 16);

    logic [4:0] opc;
    imm_fmt_e   fmt;
    ctl_t       ctl;
    op_class_e  cls;
    logic       known;
    logic       use_rd, use_rs1, use_rs2;
    logic       bad_reg, bad;

    assign opc = inst[6:2];

    always_comb begin
        ctl     = '0;
        cls     = CLS_INVALID;
        fmt     = IMM_NONE;
        known   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (1'b1)
            opc == OPC_LUI: begin
                cls = CLS_LUI;
                fmt = IMM_U;
                use_rd = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.imm_b_sel = 1'b1;
            end
            opc == OPC_AUIPC: begin
                cls = CLS_AUIPC;
                fmt = IMM_U;
                use_rd = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.imm_b_sel = 1'b1;
                ctl.pc_a_sel = 1'b1;
            end
            opc == OPC_JAL: begin
                cls = CLS_JAL;
                fmt = IMM_J;
                use_rd = 1'b1;
                ctl.is_jal = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.pc_a_sel = 1'b1;
            end
            opc == OPC_JALR: begin
                cls = CLS_JALR;
                fmt = IMM_I;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                ctl.is_jalr = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.rs1_en = 1'b1;
            end
            opc == OPC_BRANCH: begin
                cls = CLS_BRANCH;
                fmt = IMM_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctl.is_branch = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rs1_en = 1'b1;
                ctl.rs2_en = 1'b1;
                ctl.imm_en = 1'b1;
            end
            opc == OPC_LOAD: begin
                cls = CLS_LOAD;
                fmt = IMM_I;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                ctl.mem_en = 1'b1;
                ctl.rs1_en = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.rd_we = 1'b1;
            end
            opc == OPC_STORE: begin
                cls = CLS_STORE;
                fmt = IMM_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctl.mem_en = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.rs1_en = 1'b1;
                ctl.rs2_en = 1'b1;
                ctl.imm_en = 1'b1;
            end
            opc == OPC_OPIMM: begin
                cls = CLS_OPIMM;
                fmt = IMM_I;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.rs1_en = 1'b1;
                ctl.imm_en = 1'b1;
                ctl.imm_b_sel = 1'b1;
            end
            opc == OPC_OP: begin
                cls = CLS_OP;
                use_rd = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctl.alu_en = 1'b1;
                ctl.rd_we = 1'b1;
                ctl.rs1_en = 1'b1;
                ctl.rs2_en = 1'b1;
            end
            opc == OPC_MISC: begin
                cls = CLS_FENCE;
                ctl.is_fence = 1'b1;
            end
            opc == OPC_SYSTEM: begin
                cls = CLS_SYSTEM;
                ctl.is_system = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    // RV32E: only fields the format actually reads may fault
    assign bad_reg = RV32E &&
                     ((use_rd  && inst[11]) ||
                      (use_rs1 && inst[19]) ||
                      (use_rs2 && inst[24]));

    assign bad = !known || (inst[1:0] != 2'b11) || bad_reg;

    always_comb begin
        dec          = '0;
        dec.rd       = inst[11:7];
        dec.rs1      = inst[19:15];
        dec.rs2      = inst[24:20];
        dec.funct3   = inst[14:12];
        dec.alu_flag = inst[30];
        dec.op_class = bad ? CLS_INVALID : cls;
        dec.ctl      = bad ? '0 : ctl;
        dec.invalid  = bad;
    end

    assign imm = XLEN'($signed(imm_gen(inst[31:7], fmt)));

endmodule

// File: rtl/decode_queue.sv
// Instruction FIFO feeding a registered decode output with
// valid/ready flow control, flush, NOP elision and invalid count.
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int NREGS    = 32,
    parameter int DROP_NOP = 1
) (
    input logic           clk,
    input logic           reset,
    decode_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]     inst_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;

    logic            push, pop, load, drop, nonempty;
    logic [31:0]     head;
    dec_t            hd;
    logic [XLEN-1:0] hd_imm;

    dec_t            out_r;
    logic [XLEN-1:0] imm_r, pc_r;
    logic            vld;
    logic [7:0]      inv_cnt;

    assign head     = inst_q[rptr];
    assign nonempty = (count != '0);

    assign bus.in_ready = !reset && !bus.flush &&
                          (count < (AW+1)'(DEPTH));

    assign push = bus.in_valid && bus.in_ready;
    assign drop = (DROP_NOP != 0) && nonempty &&
                  (head == NOP_INST);
    assign load = !drop && nonempty && (!vld || bus.out_ready);
    assign pop  = drop || load;

    inst_decode_comb #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_dec (
        .inst (head),
        .dec  (hd),
        .imm  (hd_imm)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wptr] <= bus.in_inst;
            pc_q[wptr]   <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Fields only change on load, so a stalled output holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld     <= 1'b0;
            out_r   <= '0;
            imm_r   <= '0;
            pc_r    <= '0;
            inv_cnt <= '0;
        end else if (bus.flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld   <= 1'b1;
            out_r <= hd;
            imm_r <= hd_imm;
            pc_r  <= pc_q[rptr];
            if (hd.invalid && inv_cnt != 8'hFF)
                inv_cnt <= inv_cnt + 8'd1;
        end else if (bus.out_ready) begin
            vld <= 1'b0;
        end
    end

    assign bus.out_valid  = vld;
    assign bus.out_pc     = pc_r;
    assign bus.rd         = out_r.rd;
    assign bus.rs1        = out_r.rs1;
    assign bus.rs2        = out_r.rs2;
    assign bus.funct3     = out_r.funct3;
    assign bus.alu_flag   = out_r.alu_flag;
    assign bus.imm        = imm_r;
    assign bus.op_class   = out_r.op_class;
    assign bus.rd_we      = out_r.ctl.rd_we;
    assign bus.rs1_en     = out_r.ctl.rs1_en;
    assign bus.rs2_en     = out_r.ctl.rs2_en;
    assign bus.imm_en     = out_r.ctl.imm_en;
    assign bus.imm_b_sel  = out_r.ctl.imm_b_sel;
    assign bus.pc_a_sel   = out_r.ctl.pc_a_sel;
    assign bus.alu_en     = out_r.ctl.alu_en;
    assign bus.mem_en     = out_r.ctl.mem_en;
    assign bus.mem_write  = out_r.ctl.mem_write;
    assign bus.is_jal     = out_r.ctl.is_jal;
    assign bus.is_jalr    = out_r.ctl.is_jalr;
    assign bus.is_branch  = out_r.ctl.is_branch;
    assign bus.is_fence   = out_r.ctl.is_fence;
    assign bus.is_system  = out_r.ctl.is_system;
    assign bus.is_invalid = out_r.invalid;
    assign bus.inv_cnt    = inv_cnt;

endmodule
